dcache_responder: RTL and testbench

- Memory-side responder for the CPU data port: services addr/re/we/din and returns dout plus a stall flag.
- Direct-mapped, write-through, no-write-allocate data cache.
- On a read miss it fills a full line from backing memory over a valid/ready request channel and a response beat stream.
- Stall stays high until the transaction resolves. The CPU holds its request stable while stall is high.

---
 rtl/dcache_responder.sv | 320 ++++++++++++++++++++++++++++++++
 tb/tb_dcache_responder.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_responder.sv
// -----------------------------------------------------------------------------
// dcache_responder
//
// Memory-side responder for the CPU data port. Implements a direct-mapped,
// write-through, no-write-allocate data cache. A read hit returns data one
// cycle after acceptance. A read miss fetches a full line from backing memory
// over a valid/ready request channel followed by an ascending beat stream.
// Writes are forwarded to backing memory as single-word masked writes. On a
// hit, the cached copy is merged at the acceptance edge.
//
// Build option:
//   DCACHE_WRITE_BUFFER_EN - adds a single-entry posted write buffer. A write
//   accepted with the buffer free does not stall the CPU. The buffer drains
//   while the controller is idle. With the macro undefined, every write
//   stalls in WRITE until backing memory accepts it.
//
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   cpu_addr        - CPU byte address (ADDR_W)
//   cpu_re          - read request
//   cpu_we[3:0]     - byte write enables (lane i = bit i)
//   cpu_din[31:0]   - lane-aligned write data
//   cpu_dout[31:0]  - read data (holds until the next read completes)
//   stall           - high while a transaction is outstanding
//   mem_req_*       - backing request channel (valid/ready, rnw, addr, data,
//                     mask)
//   mem_resp_*      - backing read beats, words in ascending order
// -----------------------------------------------------------------------------
module dcache_responder #(
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 64,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_re,
  input  logic [3:0]        cpu_we,
  input  logic [31:0]       cpu_din,
  output logic [31:0]       cpu_dout,
  output logic              stall,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_rnw,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [31:0]       mem_req_data,
  output logic [3:0]        mem_req_mask,
  input  logic              mem_resp_valid,
  input  logic [31:0]       mem_resp_data
);

  localparam int WORD_W = $clog2(LINE_WORDS);
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int WLO    = 2;
  localparam int ILO    = WLO + WORD_W;
  localparam int TLO    = ILO + IDX_W;
  localparam int TAG_W  = ADDR_W - TLO;
  localparam int AW     = IDX_W + WORD_W;
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WRITE      = 3'd1,
    ST_FILL_REQ   = 3'd2,
    ST_FILL_WAIT  = 3'd3,
    ST_WRITE_WAIT = 3'd4,
    ST_MISS_WAIT  = 3'd5
  } state_t;

  // Byte-lane merge of new write data into an existing word.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  mask);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = mask[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    end
    return res;
  endfunction

  state_t               state_r;
  logic [NUM_LINES-1:0] valid_r;
  logic [TAG_W-1:0]     tag_r  [NUM_LINES];
  logic [31:0]          data_r [NUM_LINES*LINE_WORDS];
  logic [WORD_W-1:0]    cnt_r;
  logic [ADDR_W-1:0]    req_addr_r;

  logic [IDX_W-1:0]     idx_s;
  logic [WORD_W-1:0]    word_s;
  logic [TAG_W-1:0]     tag_s;
  logic                 hit_s;
  logic [31:0]          rd_word_s;
  logic [IDX_W-1:0]     req_idx_s;
  logic [WORD_W-1:0]    req_word_s;
  logic [TAG_W-1:0]     req_tag_s;
  logic                 wr_acc_s;
  logic                 beat_s;
  logic                 last_beat_s;
  logic                 arr_we_s;
  logic [AW-1:0]        arr_waddr_s;
  logic [31:0]          arr_wdata_s;
  logic                 unused_s;

`ifdef DCACHE_WRITE_BUFFER_EN
  // The mem_req_* registers double as the single buffer entry.
  logic                 wb_full_r;
  logic [31:0]          req_data_r;
  logic [3:0]           req_mask_r;
  logic                 drain_done_s;
  logic                 wb_free_s;
`endif

  assign idx_s       = cpu_addr[ILO +: IDX_W];
  assign word_s      = cpu_addr[WLO +: WORD_W];
  assign tag_s       = cpu_addr[TLO +: TAG_W];
  assign hit_s       = valid_r[idx_s] && (tag_r[idx_s] == tag_s);
  assign rd_word_s   = data_r[{idx_s, word_s}];
  assign req_idx_s   = req_addr_r[ILO +: IDX_W];
  assign req_word_s  = req_addr_r[WLO +: WORD_W];
  assign req_tag_s   = req_addr_r[TLO +: TAG_W];
  assign wr_acc_s    = (state_r == ST_IDLE) && (cpu_we != 4'b0000);
  assign beat_s      = (state_r == ST_FILL_WAIT) && mem_resp_valid;
  assign last_beat_s = beat_s && (cnt_r == LAST_WORD);
  assign stall       = (state_r != ST_IDLE);
  // Byte-offset bits never select anything in a word-wide cache.
  assign unused_s    = ^{cpu_addr[1:0], req_addr_r[1:0]};

`ifdef DCACHE_WRITE_BUFFER_EN
  // A drain that completes on this edge frees the buffer for a new request.
  assign drain_done_s = (state_r == ST_IDLE) && wb_full_r && mem_req_ready;
  assign wb_free_s    = !wb_full_r || drain_done_s;
`endif

  // Data array write port select: write-hit merge or fill beat.
  always_comb begin
    arr_we_s    = 1'b0;
    arr_waddr_s = '0;
    arr_wdata_s = 32'h0000_0000;
    if (rst) begin
      arr_we_s = 1'b0;
    end else if (wr_acc_s && hit_s) begin
      arr_we_s    = 1'b1;
      arr_waddr_s = {idx_s, word_s};
      arr_wdata_s = merge_bytes(rd_word_s, cpu_din, cpu_we);
    end else if (beat_s) begin
      arr_we_s    = 1'b1;
      arr_waddr_s = {req_idx_s, cnt_r};
      arr_wdata_s = mem_resp_data;
    end else begin
      arr_we_s = 1'b0;
    end
  end

  // Data storage (no reset; contents are qualified by valid_r).
  always_ff @(posedge clk) begin
    if (arr_we_s) begin
      data_r[arr_waddr_s] <= arr_wdata_s;
    end
  end

  // Tag storage, written when a fill completes.
  always_ff @(posedge clk) begin
    if (!rst && last_beat_s) begin
      tag_r[req_idx_s] <= req_tag_s;
    end
  end

  // Controller FSM with registered CPU and memory-side outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      valid_r       <= '0;
      cnt_r         <= '0;
      req_addr_r    <= '0;
      cpu_dout      <= 32'h0000_0000;
      mem_req_valid <= 1'b0;
      mem_req_rnw   <= 1'b1;
      mem_req_addr  <= '0;
      mem_req_data  <= 32'h0000_0000;
      mem_req_mask  <= 4'b0000;
`ifdef DCACHE_WRITE_BUFFER_EN
      wb_full_r     <= 1'b0;
      req_data_r    <= 32'h0000_0000;
      req_mask_r    <= 4'b0000;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
`ifdef DCACHE_WRITE_BUFFER_EN
          if (drain_done_s) begin
            wb_full_r     <= 1'b0;
            mem_req_valid <= 1'b0;
          end
`endif
          if (cpu_we != 4'b0000) begin
            // Write has priority over a simultaneous read.
            req_addr_r <= cpu_addr;
`ifdef DCACHE_WRITE_BUFFER_EN
            if (wb_free_s) begin
              wb_full_r     <= 1'b1;
              mem_req_valid <= 1'b1;
              mem_req_rnw   <= 1'b0;
              mem_req_addr  <= {cpu_addr[ADDR_W-1:2], 2'b00};
              mem_req_data  <= cpu_din;
              mem_req_mask  <= cpu_we;
            end else begin
              req_data_r <= cpu_din;
              req_mask_r <= cpu_we;
              state_r    <= ST_WRITE_WAIT;
            end
`else
            mem_req_valid <= 1'b1;
            mem_req_rnw   <= 1'b0;
            mem_req_addr  <= {cpu_addr[ADDR_W-1:2], 2'b00};
            mem_req_data  <= cpu_din;
            mem_req_mask  <= cpu_we;
            state_r       <= ST_WRITE;
`endif
          end else if (cpu_re) begin
            req_addr_r <= cpu_addr;
            if (hit_s) begin
              cpu_dout <= rd_word_s;
            end else begin
`ifdef DCACHE_WRITE_BUFFER_EN
              if (wb_free_s) begin
                mem_req_valid <= 1'b1;
                mem_req_rnw   <= 1'b1;
                mem_req_addr  <= {cpu_addr[ADDR_W-1:ILO], {ILO{1'b0}}};
                state_r       <= ST_FILL_REQ;
              end else begin
                state_r <= ST_MISS_WAIT;
              end
`else
              mem_req_valid <= 1'b1;
              mem_req_rnw   <= 1'b1;
              mem_req_addr  <= {cpu_addr[ADDR_W-1:ILO], {ILO{1'b0}}};
              state_r       <= ST_FILL_REQ;
`endif
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end

        ST_WRITE: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state_r       <= ST_IDLE;
          end else begin
            state_r <= ST_WRITE;
          end
        end

        ST_FILL_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid      <= 1'b0;
            cnt_r              <= '0;
            // The line is being overwritten; it is not usable until complete.
            valid_r[req_idx_s] <= 1'b0;
            state_r            <= ST_FILL_WAIT;
          end else begin
            state_r <= ST_FILL_REQ;
          end
        end

        ST_FILL_WAIT: begin
          if (mem_resp_valid) begin
            cnt_r <= cnt_r + WORD_W'(1);
            if (cnt_r == LAST_WORD) begin
              valid_r[req_idx_s] <= 1'b1;
              // The requested word may be the beat arriving right now.
              cpu_dout <= (req_word_s == cnt_r) ? mem_resp_data
                                                : data_r[{req_idx_s, req_word_s}];
              state_r  <= ST_IDLE;
            end else begin
              state_r <= ST_FILL_WAIT;
            end
          end else begin
            state_r <= ST_FILL_WAIT;
          end
        end

`ifdef DCACHE_WRITE_BUFFER_EN
        ST_WRITE_WAIT: begin
          // Old entry drains on this handshake; the held write takes its place.
          if (mem_req_ready) begin
            wb_full_r     <= 1'b1;
            mem_req_valid <= 1'b1;
            mem_req_rnw   <= 1'b0;
            mem_req_addr  <= {req_addr_r[ADDR_W-1:2], 2'b00};
            mem_req_data  <= req_data_r;
            mem_req_mask  <= req_mask_r;
            state_r       <= ST_IDLE;
          end else begin
            state_r <= ST_WRITE_WAIT;
          end
        end

        ST_MISS_WAIT: begin
          if (mem_req_ready) begin
            wb_full_r     <= 1'b0;
            mem_req_valid <= 1'b1;
            mem_req_rnw   <= 1'b1;
            mem_req_addr  <= {req_addr_r[ADDR_W-1:ILO], {ILO{1'b0}}};
            state_r       <= ST_FILL_REQ;
          end else begin
            state_r <= ST_MISS_WAIT;
          end
        end
`endif

        default: begin
          mem_req_valid <= 1'b0;
          state_r       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_responder.sv
// -----------------------------------------------------------------------------
// tb_dcache_responder
//
// Directed testbench for dcache_responder. Inputs change 1 ns after the rising
// edge, and outputs are checked at the same point, away from the active edge.
// The backing memory is scripted by hand inside the stimulus sequence.
// -----------------------------------------------------------------------------
module tb_dcache_responder;

  logic        clk;
  logic        rst;
  logic [31:0] cpu_addr;
  logic        cpu_re;
  logic [3:0]  cpu_we;
  logic [31:0] cpu_din;
  logic [31:0] cpu_dout;
  logic        stall;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_rnw;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_data;
  logic [3:0]  mem_req_mask;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;

  int n_cmp;
  int n_err;

  dcache_responder #(
    .LINE_WORDS(4),
    .NUM_LINES (64),
    .ADDR_W    (32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cpu_addr      (cpu_addr),
    .cpu_re        (cpu_re),
    .cpu_we        (cpu_we),
    .cpu_din       (cpu_din),
    .cpu_dout      (cpu_dout),
    .stall         (stall),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_rnw   (mem_req_rnw),
    .mem_req_addr  (mem_req_addr),
    .mem_req_data  (mem_req_data),
    .mem_req_mask  (mem_req_mask),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_data (mem_resp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Four fill beats starting at base; the last edge ends the fill.
  task automatic send_beats(input logic [31:0] base);
    for (int i = 0; i < 4; i++) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = base + 32'(i);
      tick();
    end
    mem_resp_valid = 1'b0;
    mem_resp_data  = 32'h0000_0000;
  endtask

  initial begin
    n_cmp          = 0;
    n_err          = 0;
    rst            = 1'b1;
    cpu_addr       = 32'h0000_0000;
    cpu_re         = 1'b0;
    cpu_we         = 4'b0000;
    cpu_din        = 32'h0000_0000;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = 32'h0000_0000;
    tick();
    tick();

    // Reset state
    check_eq("rst_stall", {31'd0, stall}, 32'd0);
    check_eq("rst_dout", cpu_dout, 32'h0000_0000);
    check_eq("rst_valid", {31'd0, mem_req_valid}, 32'd0);
    check_eq("rst_rnw", {31'd0, mem_req_rnw}, 32'd1);
    check_eq("rst_addr", mem_req_addr, 32'h0000_0000);
    check_eq("rst_data", mem_req_data, 32'h0000_0000);
    check_eq("rst_mask", {28'd0, mem_req_mask}, 32'd0);

    // Read miss at 0x1000_0010 with immediate ready
    rst           = 1'b0;
    cpu_addr      = 32'h1000_0010;
    cpu_re        = 1'b1;
    mem_req_ready = 1'b1;
    tick();
    check_eq("miss1_stall", {31'd0, stall}, 32'd1);
    check_eq("miss1_req_valid", {31'd0, mem_req_valid}, 32'd1);
    check_eq("miss1_req_rnw", {31'd0, mem_req_rnw}, 32'd1);
    check_eq("miss1_req_addr", mem_req_addr, 32'h1000_0010);
    tick();
    check_eq("miss1_req_done", {31'd0, mem_req_valid}, 32'd0);
    check_eq("miss1_wait_stall", {31'd0, stall}, 32'd1);
    mem_req_ready = 1'b0;
    send_beats(32'h0000_00A0);
    check_eq("miss1_end_stall", {31'd0, stall}, 32'd0);
    check_eq("miss1_dout", cpu_dout, 32'h0000_00A0);

    // Read hit at 0x1000_0018 (word 2)
    cpu_addr = 32'h1000_0018;
    tick();
    check_eq("hit_stall", {31'd0, stall}, 32'd0);
    check_eq("hit_dout", cpu_dout, 32'h0000_00A2);
    check_eq("hit_no_req", {31'd0, mem_req_valid}, 32'd0);
    cpu_re = 1'b0;

`ifndef DCACHE_WRITE_BUFFER_EN
    // Partial write hit with ready held low for three cycles
    cpu_addr = 32'h1000_0014;
    cpu_we   = 4'b0011;
    cpu_din  = 32'h0000_BEEF;
    tick();
    check_eq("wr_stall_c1", {31'd0, stall}, 32'd1);
    check_eq("wr_valid", {31'd0, mem_req_valid}, 32'd1);
    check_eq("wr_rnw", {31'd0, mem_req_rnw}, 32'd0);
    check_eq("wr_addr", mem_req_addr, 32'h1000_0014);
    check_eq("wr_mask", {28'd0, mem_req_mask}, 32'h0000_0003);
    // Captured fields must not follow later CPU input changes
    cpu_we   = 4'b0000;
    cpu_din  = 32'hFFFF_FFFF;
    cpu_addr = 32'h2000_0000;
    tick();
    check_eq("wr_stall_c2", {31'd0, stall}, 32'd1);
    tick();
    check_eq("wr_stall_c3", {31'd0, stall}, 32'd1);
    mem_req_ready = 1'b1;
    check_eq("wr_stall_c4", {31'd0, stall}, 32'd1);
    check_eq("wr_data_held", mem_req_data, 32'h0000_BEEF);
    check_eq("wr_addr_held", mem_req_addr, 32'h1000_0014);
    tick();
    check_eq("wr_done_stall", {31'd0, stall}, 32'd0);
    check_eq("wr_done_valid", {31'd0, mem_req_valid}, 32'd0);
    mem_req_ready = 1'b0;
    cpu_addr = 32'h1000_0014;
    cpu_re   = 1'b1;
    tick();
    check_eq("wr_merge_dout", cpu_dout, 32'h0000_BEEF);
    cpu_re = 1'b0;

    // Write miss: memory write only, no fill
    cpu_addr      = 32'h1000_4000;
    cpu_we        = 4'b1111;
    cpu_din       = 32'h1234_5678;
    mem_req_ready = 1'b1;
    tick();
    check_eq("wmiss_rnw", {31'd0, mem_req_rnw}, 32'd0);
    check_eq("wmiss_addr", mem_req_addr, 32'h1000_4000);
    cpu_we = 4'b0000;
    tick();
    check_eq("wmiss_done", {31'd0, mem_req_valid}, 32'd0);
    check_eq("wmiss_nostall", {31'd0, stall}, 32'd0);
    mem_req_ready = 1'b0;
`else
    // Two posted writes with ready low
    cpu_addr = 32'h1000_0014;
    cpu_we   = 4'b1111;
    cpu_din  = 32'h1111_1111;
    tick();
    check_eq("wb1_nostall", {31'd0, stall}, 32'd0);
    check_eq("wb1_valid", {31'd0, mem_req_valid}, 32'd1);
    check_eq("wb1_addr", mem_req_addr, 32'h1000_0014);
    cpu_addr = 32'h1000_0018;
    cpu_din  = 32'h2222_2222;
    tick();
    check_eq("wb2_stall", {31'd0, stall}, 32'd1);
    check_eq("wb2_first_held", mem_req_data, 32'h1111_1111);
    tick();
    check_eq("wb2_stall_c2", {31'd0, stall}, 32'd1);
    mem_req_ready = 1'b1;
    tick();
    cpu_we = 4'b0000;
    check_eq("wb2_released", {31'd0, stall}, 32'd0);
    check_eq("wb2_second_addr", mem_req_addr, 32'h1000_0018);
    check_eq("wb2_second_data", mem_req_data, 32'h2222_2222);
    check_eq("wb2_second_rnw", {31'd0, mem_req_rnw}, 32'd0);
    tick();
    check_eq("wb2_drained", {31'd0, mem_req_valid}, 32'd0);
    mem_req_ready = 1'b0;
    cpu_addr = 32'h1000_0014;
    cpu_re   = 1'b1;
    tick();
    check_eq("wb_merge_dout", cpu_dout, 32'h1111_1111);
    cpu_re = 1'b0;
`endif

    // Read miss at 0x1000_4000, reset during the second fill beat
    cpu_addr = 32'h1000_4000;
    cpu_re   = 1'b1;
    tick();
    check_eq("miss2_stall", {31'd0, stall}, 32'd1);
    check_eq("miss2_rnw", {31'd0, mem_req_rnw}, 32'd1);
    check_eq("miss2_addr", mem_req_addr, 32'h1000_4000);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h0000_00B0;
    tick();
    mem_resp_data = 32'h0000_00B1;
    rst           = 1'b1;
    tick();
    check_eq("rstmid_stall", {31'd0, stall}, 32'd0);
    check_eq("rstmid_valid", {31'd0, mem_req_valid}, 32'd0);
    rst            = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = 32'h0000_0000;
    tick();
    check_eq("remiss_stall", {31'd0, stall}, 32'd1);
    check_eq("remiss_valid", {31'd0, mem_req_valid}, 32'd1);
    check_eq("remiss_addr", mem_req_addr, 32'h1000_4000);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    send_beats(32'h0000_00C0);
    check_eq("refill_stall", {31'd0, stall}, 32'd0);
    check_eq("refill_dout", cpu_dout, 32'h0000_00C0);

    // Hit on the last word of the refilled line
    cpu_addr = 32'h1000_400C;
    tick();
    check_eq("hit3_dout", cpu_dout, 32'h0000_00C3);

`ifndef DCACHE_WRITE_BUFFER_EN
    // Read and write together: the write wins and dout is untouched
    cpu_addr = 32'h1000_4008;
    cpu_we   = 4'b1111;
    cpu_din  = 32'hDEAD_BEEF;
    tick();
    check_eq("both_rnw", {31'd0, mem_req_rnw}, 32'd0);
    check_eq("both_stall", {31'd0, stall}, 32'd1);
    check_eq("both_dout_hold", cpu_dout, 32'h0000_00C3);
    cpu_we        = 4'b0000;
    cpu_re        = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    cpu_re        = 1'b1;
    tick();
    check_eq("both_merge_dout", cpu_dout, 32'hDEAD_BEEF);
`endif
    cpu_re = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
